uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between NUM_REQ byte sources, e.g. the rx echo path and a status/message source.
//  Round-robin arbitration, one byte per grant. Drives the transmitter's send/data inputs and tracks its busy flag.
//  Sits between the requesters and uart_tx in the top level.
// PARAMETERS
//  NUM_REQ        2   number of requesters (2..8)
//  START_TIMEOUT  16  cycles to wait for tx_busy to rise after tx_send before abandoning the wait
// PORTS
//  clk        in   1          system clock; all logic on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_valid  in   NUM_REQ    requester i has a byte on req_data[8*i+:8]
//  req_data   in   8*NUM_REQ  packed request bytes; requester i at bits [8*i+7:8*i]
//  req_ready  out  NUM_REQ    one-hot, 1-cycle accept pulse; byte consumed when valid&ready
//  tx_send    out  1          1-cycle start pulse to uart_tx
//  tx_data    out  8          byte to uart_tx; held stable from tx_send until back in IDLE
//  tx_busy    in   1          high while uart_tx shifts a frame
//  grant_id   out  GW         index of the last/current grant; GW = $clog2(NUM_REQ)
//  active     out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=0, tx_send=0, tx_data=8'h00, grant_id=0, active=0.
//  Reset: rr pointer=NUM_REQ-1, so requester 0 has priority first.
//  Reset mid-frame: the FSM returns to IDLE the next cycle and never re-sends the byte. uart_tx is not reset by this block.
//  Requesters hold req_valid/req_data stable until accepted. A request cannot be withdrawn.
//  Round-robin: search starts at rr+1 mod NUM_REQ; the first valid index wins; rr := winner on accept.
//  FSM states:
//   IDLE: if any req_valid and tx_busy==0:
//    - pulse req_ready[w]; latch tx_data<=req_data[w] and grant_id<=w
//    - go to SEND
//   IDLE: if tx_busy==1, wait; nothing is granted.
//   SEND: tx_send=1 for exactly this cycle; go to WAIT_START and clear the timer.
//   WAIT_START: tx_busy==1 -> WAIT_DONE.
//   WAIT_START: if the timer reaches START_TIMEOUT-1 with tx_busy still low -> IDLE. The byte counts as sent; it is not retried.
//   WAIT_DONE: tx_busy==0 -> IDLE.
//  Latency: req_valid to req_ready is 1 cycle; req_ready to tx_send is 1 cycle.
//  Minimum spacing between two tx_send pulses is 4 cycles plus the frame time.
//  A single requester holding valid continuously is served back-to-back.
//  Several requesters holding valid continuously are served strictly in turn (0,1,..,N-1,0,...).
//  A requester is starved for at most NUM_REQ-1 frames.
//  When a requester asserts valid in the same cycle a grant is issued, it joins the next arbitration.
//  All outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  Shared package uart_pkg: FSM state enum (IDLE, SEND, WAIT_START, WAIT_DONE) and the byte-width constant (8).
//  Sub-module rr_arbiter: NUM_REQ-wide, combinational; inputs req and last-grant pointer; outputs one-hot grant and index.
//  The FSM, data latch and timeout counter ($clog2(START_TIMEOUT) bits) live in this module.
// TESTING
//  - Reset release with no requests: all outputs 0 and active=0 for 20 cycles.
//  - req0 valid with 8'h41, tx_busy model rises 1 cycle after send and stays high 10 cycles:
//    ready0 at cycle 1, tx_send at cycle 2 with tx_data=8'h41, back to IDLE after busy falls.
//  - req0=8'hAA and req1=8'h55 held valid for 4 grants: sends AA,55,AA,55; grant_id 0,1,0,1.
//  - tx_busy held low (dead transmitter): after each tx_send the block returns to IDLE after exactly START_TIMEOUT cycles in WAIT_START.
//  - rst asserted during WAIT_DONE: next cycle active=0; after rst drops, no extra tx_send until a new req_valid.
//  - tx_busy high at the moment req_valid rises: no req_ready until busy falls, then the grant follows on the next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SEND       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts one past the last grant and wraps.
module rr_arbiter #(
    parameter int  NUM_REQ = 2,
    localparam int GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      grant_idx,
    output logic               any
);

    logic [GW-1:0] cand;

    function automatic logic [GW-1:0] wrap_idx(input int v);
        return GW'(v % NUM_REQ);
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = wrap_idx(int'(last) + k);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte sources, one byte per grant.
//
//  state      | meaning
//  -----------+---------------------------------------------------------------
//  IDLE       | transmitter free; arbitrate and accept one byte
//  SEND       | byte latched; tx_send fires on the way out of this state
//  WAIT_START | waiting for tx_busy to rise, bounded by START_TIMEOUT cycles
//  WAIT_DONE  | frame in flight; wait for tx_busy to fall
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  NUM_REQ       = 2,
    parameter int  START_TIMEOUT = 16,
    localparam int GW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TW            = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_send,
    output logic [BYTE_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic [GW-1:0]             grant_id,
    output logic                      active
);

    localparam logic [TW-1:0] TIMER_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] RR_RESET   = GW'(NUM_REQ - 1);

    tx_state_t state, state_nxt;

    logic [GW-1:0]      rr_ptr, rr_nxt;
    logic [TW-1:0]      timer, timer_nxt;
    logic [NUM_REQ-1:0] req_ready_nxt;
    logic               tx_send_nxt;
    logic [BYTE_W-1:0]  tx_data_nxt;
    logic [GW-1:0]      grant_id_nxt;

    logic [NUM_REQ-1:0] arb_grant;
    logic [GW-1:0]      arb_idx;
    logic               arb_any;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req       (req_valid),
        .last      (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= RR_RESET;
            timer     <= '0;
            req_ready <= '0;
            tx_send   <= 1'b0;
            tx_data   <= '0;
            grant_id  <= '0;
            active    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_nxt;
            timer     <= timer_nxt;
            req_ready <= req_ready_nxt;
            tx_send   <= tx_send_nxt;
            tx_data   <= tx_data_nxt;
            grant_id  <= grant_id_nxt;
            active    <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        timer_nxt     = timer;
        req_ready_nxt = '0;
        tx_send_nxt   = 1'b0;
        tx_data_nxt   = tx_data;
        grant_id_nxt  = grant_id;

        case (state)
            IDLE: begin
                if (arb_any && !tx_busy) begin
                    req_ready_nxt = arb_grant;
                    tx_data_nxt   = req_data[int'(arb_idx)*BYTE_W +: BYTE_W];
                    grant_id_nxt  = arb_idx;
                    rr_nxt        = arb_idx;
                    state_nxt     = SEND;
                end
            end
            SEND: begin
                tx_send_nxt = 1'b1;
                timer_nxt   = '0;
                state_nxt   = WAIT_START;
            end
            WAIT_START: begin
                // A transmitter that never goes busy still counts the byte as sent.
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
